// File: rtl/encode_ctl.sv
// encode_ctl: LZS token sequencer that turns literal/match/end tokens into codeword beats for the bit packer.
// Ports: tok_* token handshake in; done_i packer done in; cnt_output_enable/cnt_output/cnt_len beats out;
// cnt_finish stream-finished flag; err_o sticky protocol error. clk rising edge, rst_n async active-low.
module encode_ctl #(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_type,
  input  logic [7:0]       tok_lit,
  input  logic [10:0]      tok_off,
  input  logic [LEN_W-1:0] tok_len,
  input  logic             done_i,
  output logic             cnt_output_enable,
  output logic [12:0]      cnt_output,
  output logic [3:0]       cnt_len,
  output logic             cnt_finish,
  output logic             err_o
);
  typedef enum logic [2:0] {IDLE, LEN, EXT, PAD, FIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d, ext;
  logic [3:0] pos_q, pos_d, len_q, len_d, nib;
  logic [12:0] out_q, out_d;
  logic en_q, en_d, fin_q, fin_d, err_q, err_d, bad;
  always_comb begin
    // In LEN the stored value is the full length; the nibble codes len-8. In EXT it is already the remainder.
    ext = (state_q == LEN) ? rem_q - LEN_W'(8) : rem_q;
    nib = (ext > LEN_W'(15)) ? 4'hF : ext[3:0];
    bad = (tok_type == 2'b11) || (tok_type == 2'b01 && (tok_off == 11'd0 || tok_len < LEN_W'(2)));
    state_d = state_q;
    rem_d = rem_q;
    en_d = 1'b0;
    out_d = 13'd0;
    len_d = 4'd0;
    fin_d = fin_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (tok_valid) begin
        if (bad) err_d = 1'b1;
        else if (tok_type == 2'b00) begin
          en_d = 1'b1;
          out_d = {5'd0, tok_lit};
          len_d = 4'd9;
        end else if (tok_type == 2'b01) begin
          en_d = 1'b1;
          out_d = (tok_off < 11'd128) ? {4'd0, 2'b11, tok_off[6:0]} : {2'b10, tok_off};
          len_d = (tok_off < 11'd128) ? 4'd9 : 4'd13;
          rem_d = tok_len;
          state_d = LEN;
        end else begin
          en_d = 1'b1;
          out_d = 13'h180;
          len_d = 4'd9;
          state_d = PAD;
        end
      end
      LEN: begin
        en_d = 1'b1;
        state_d = IDLE;
        if (rem_q < LEN_W'(5)) begin
          // 2,3,4 map to 00,01,10 via the low two bits minus 2
          out_d = {11'd0, rem_q[1:0] - 2'd2};
          len_d = 4'd2;
        end else if (rem_q < LEN_W'(8)) begin
          out_d = {9'd0, rem_q[3:0] + 4'd7};
          len_d = 4'd4;
        end else begin
          out_d = {5'd0, 4'hF, nib};
          len_d = 4'd8;
          if (nib == 4'hF) begin
            rem_d = ext - LEN_W'(15);
            state_d = EXT;
          end
        end
      end
      EXT: begin
        en_d = 1'b1;
        out_d = {9'd0, nib};
        len_d = 4'd4;
        rem_d = ext - LEN_W'(15);
        state_d = (nib == 4'hF) ? EXT : IDLE;
      end
      PAD: begin
        state_d = FIN;
        if (pos_q != 4'd0) begin
          en_d = 1'b1;
          len_d = 4'd0 - pos_q;
        end else fin_d = 1'b1;
      end
      FIN: begin
        fin_d = !(fin_q && done_i);
        state_d = (fin_q && done_i) ? IDLE : FIN;
      end
      default: state_d = IDLE;
    endcase
    pos_d = (state_q == FIN && state_d == IDLE) ? 4'd0 : pos_q + len_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      pos_q <= 4'd0;
      en_q <= 1'b0;
      out_q <= 13'd0;
      len_q <= 4'd0;
      fin_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      pos_q <= pos_d;
      en_q <= en_d;
      out_q <= out_d;
      len_q <= len_d;
      fin_q <= fin_d;
      err_q <= err_d;
    end
  end
  assign tok_ready = (state_q == IDLE);
  assign cnt_output_enable = en_q;
  assign cnt_output = out_q;
  assign cnt_len = len_q;
  assign cnt_finish = fin_q;
  assign err_o = err_q;
endmodule

// File: doc/encode_ctl.md
# encode_ctl

Token sequencer feeding the `encode_out` bit packer in the LZS encode path. It accepts literal, match and end-of-stream tokens from the match finder and LZS-encodes each one into one or more `{cnt_output, cnt_len}` beats. It tracks the packer's bit position, zero-pads the stream to a 16-bit boundary after the end marker, then holds `cnt_finish` until the packer reports done.

## Interface
- `LEN_W`, default 11: match-length width; lengths 2..2^LEN_W-1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  token accepted when `tok_valid && tok_ready`.
- `tok_type`  in  2  token kind: 00 literal, 01 match, 10 end-of-stream, 11 reserved.
- `tok_lit`  in  8  literal byte.
- `tok_off`  in  11  match offset, 1..2047.
- `tok_len`  in  LEN_W  match length, ≥2.
- `done_i`  in  1  `done_o` from the packer.
- `cnt_output_enable`  out  1  beat valid; one beat per cycle max.
- `cnt_output`  out  13  codeword, right-aligned, MSB sent first.
- `cnt_len`  out  4  codeword bit count, 1..15.
- `cnt_finish`  out  1  stream finished; held until `done_i`.
- `err_o`  out  1  sticky protocol error.

## Operation
- States: IDLE, LEN, EXT, PAD, FIN. `tok_ready` = (state==IDLE), combinational.
- Beat outputs are registered. `cnt_output_enable` pulses for exactly one cycle per beat. `cnt_output` and `cnt_len` are don't-care when the enable is low and are driven 0.
- Literal: one beat, `{0, lit}`, length 9. State stays IDLE.
- Match with offset <128: first beat is `{1,1,off[6:0]}`, length 9. With offset ≥128: `{1,0,off[10:0]}`, length 13. Then go to LEN.
- LEN emits the length code:
  - 2 → 00, 3 → 01, 4 → 10 (2 bits).
  - 5 → 1100, 6 → 1101, 7 → 1110 (4 bits).
  - ≥8: rem = len-8; emit `{1111, min(rem,15)}` (8 bits).
- After LEN: if the emitted nibble was 15, set rem -= 15 and go to EXT; otherwise go to IDLE.
- EXT: emit 4-bit `min(rem,15)` each cycle. If the nibble is 15, set rem -= 15 and stay in EXT; otherwise go to IDLE. A length that leaves exactly 15 therefore ends with a 0000 nibble.
- End-of-stream: emit the end marker `110000000` (0x180, length 9), then go to PAD.
- Bit position `pos[3:0]` advances by `cnt_len` on every beat (mod 16).
- PAD: if pos≠0, emit value 0 with length (16-pos) mod 16; if pos==0, emit no beat. Then go to FIN.
- FIN: `cnt_finish`=1. When `done_i`=1: `cnt_finish`←0, pos←0, go to IDLE.
- Error tokens: match with offset 0, match with len<2, or type 11. The token is consumed, no beat is emitted, `err_o`←1, and state stays IDLE. `err_o` is cleared only by reset.
- Reset value of every output: `cnt_output_enable`=0, `cnt_output`=0, `cnt_len`=0, `cnt_finish`=0, `err_o`=0. `tok_ready`=1 (state IDLE). pos=0.

## Timing
- Token accepted at edge T → first beat visible in cycle T+1.
- Literal throughput: 1 per cycle.
- Match throughput: 2 cycles for len<8; 2+k cycles for len≥8, where k = number of EXT nibbles.
- End-of-stream: marker at T+1. Pad beat (if any) at T+2. `cnt_finish` rises at T+2 (no pad) or T+3 (pad), and stays high through the cycle `done_i` is sampled high. IDLE (ready) follows on the next cycle.
- `done_i` is ignored outside FIN.
- No backpressure from the packer: beats are never stalled.
- Reset asserted mid-token: the token is abandoned, every register returns to its reset value immediately, and no partial beat follows after release.

## Test plan
- Reset, then literal 0x41 → one beat `cnt_output`=0x041, `cnt_len`=9, next cycle `tok_ready`=1. Next: back-to-back literals 0x00, 0xFF → beats 0x000 and 0x0FF in consecutive cycles.
- Match off=5, len=2 → beats 0x185/9 then 0x000/2. `tok_ready` low for exactly 1 cycle.
- Match off=300, len=23 → beats 0x112C/13, 0x0FF/8, 0x000/4. Match off=127, len=8 → 0x1FF/9, 0x0F0/8.
- Literal then end-of-stream → 0x041/9, 0x180/9, then pad 0x000/14 (pos=2). `cnt_finish`=1 held 5 cycles until `done_i` pulses. Then `tok_ready`=1 and pos=0. A 16-bit-aligned stream (pos 0 after marker) → no pad beat.
- Match off=0 or len=1, and type 11 → no beat, `err_o`=1 sticky. Following literal 0x41 still produces 0x041/9.
- Match off=2000, len=40 accepted, `rst_n` pulled low after the first beat → all outputs 0 at once. After release: IDLE, pos=0, no further length beats.
